// File: rtl/pdl_timer_scheduler.sv
// -----------------------------------------------------------------------------
// pdl_timer_scheduler
//
// Shared-timebase scheduler for the four game-paddle timer channels. One trig
// strobe launches every enabled channel at once. A single prescaler and step
// counter sequence the run, and each channel's status bit drops when the step
// count reaches the position that was latched for it at trig time. Channel i
// with latched position p stays high for BASE_TICKS + p*STEP_TICKS cycles.
//
// Parameters
//   BASE_TICKS  lead-in cycles before step counting starts (1..1023)
//   STEP_TICKS  cycles per position step (1..1023)
//
// Ports
//   sys_clk    in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset (wins over trig)
//   trig       in   one-cycle paddle-trigger strobe, restarts any run
//   ch_en[3:0] in   per-channel enable, sampled with trig
//   pos0..pos3 in   8-bit paddle positions, sampled with trig
//   status[3:0] out per-channel timer-running bit
//   busy       out  high while the scheduler is not IDLE
//   done       out  one-cycle pulse when the last running channel clears
//   state_dbg  out  current scheduler state (0 IDLE, 1 BASE, 2 STEP)
//
// Handshake: there is no valid/ready pair here. trig is a fire-and-forget
// strobe accepted in every state; a trig always restarts the run and takes
// precedence over the clearing/ending that would otherwise happen that cycle.
// -----------------------------------------------------------------------------
module pdl_timer_scheduler #(
    parameter int BASE_TICKS = 200,
    parameter int STEP_TICKS = 582
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       trig,
    input  logic [3:0] ch_en,
    input  logic [7:0] pos0,
    input  logic [7:0] pos1,
    input  logic [7:0] pos2,
    input  logic [7:0] pos3,
    output logic [3:0] status,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BASE = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [9:0] BASE_LOAD = 10'(BASE_TICKS - 1);
    localparam logic [9:0] STEP_LOAD = 10'(STEP_TICKS - 1);

    state_t     state_q, state_d;
    logic [9:0] presc_q, presc_d;
    logic [7:0] step_q, step_d;
    logic [7:0] pos_q [4];
    logic [7:0] pos_d [4];
    logic [3:0] status_q, status_d;
    logic       done_q, done_d;
    logic [3:0] clr;
    logic [7:0] step_nxt;

    // Step count saturates at 255; every latched position is <= 255, so an
    // active run always ends by then and the counter never wraps.
    assign step_nxt = (step_q == 8'hFF) ? step_q : step_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        step_d   = step_q;
        pos_d    = pos_q;
        status_d = status_q;
        done_d   = 1'b0;
        clr      = 4'b0000;

        if (trig) begin
            // Restart: a run only starts if at least one channel is enabled.
            pos_d[0] = pos0;
            pos_d[1] = pos1;
            pos_d[2] = pos2;
            pos_d[3] = pos3;
            status_d = ch_en;
            presc_d  = BASE_LOAD;
            step_d   = 8'd0;
            state_d  = (ch_en != 4'b0000) ? BASE : IDLE;
        end else begin
            case (state_q)
                BASE: begin
                    if (presc_q == 10'd0) begin
                        for (int i = 0; i < 4; i++) begin
                            clr[i] = (pos_q[i] == 8'd0);
                        end
                        presc_d = STEP_LOAD;
                        state_d = STEP;
                    end else begin
                        presc_d = presc_q - 10'd1;
                    end
                end
                STEP: begin
                    if (presc_q == 10'd0) begin
                        step_d = step_nxt;
                        for (int i = 0; i < 4; i++) begin
                            clr[i] = (pos_q[i] == step_nxt);
                        end
                        presc_d = STEP_LOAD;
                    end else begin
                        presc_d = presc_q - 10'd1;
                    end
                end
                default: ;
            endcase

            if (state_q != IDLE) begin
                // Disabled channels are already 0, so clearing them is a no-op
                // and they cannot hold the run open.
                status_d = status_q & ~clr;
                if (status_d == 4'b0000) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= 10'd0;
            step_q   <= 8'd0;
            status_q <= 4'b0000;
            done_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            status_q <= status_d;
            done_q   <= done_d;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    assign status    = status_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
